cross_bar_slave_mem: RTL and testbench

- Slave-side responder endpoint for the crossbar req/ack protocol: consumes slave_req/addr/cmd/wdata and returns slave_ack/rdata.
- Backs the request with a small word-addressed register file, a programmable wait-state counter and an external stall input.
- Serves as a synthesizable slave model for crossbar integration benches and as a scratchpad slave in the fabric.
- One instance per crossbar slave port.

---
 rtl/cross_bar_pkg.sv | 29 ++
 rtl/cross_bar_slave_mem_array.sv | 35 +++
 rtl/cross_bar_slave_mem.sv | 132 +++++++++++++
 tb/tb_cross_bar_slave_mem.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
// Shared types for the crossbar fabric and its slave-side endpoints.
//   addr_t / data_t      : 32-bit word address and data.
//   slave_cmd_e          : request command encoding on slave_cmd.
//   slave_mem_state_e    : handshake states of cross_bar_slave_mem.
//   CNT_W / sat_inc      : width of the completion counters and their saturating increment.
package cross_bar_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } slave_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } slave_mem_state_e;

    localparam int unsigned CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cross_bar_slave_mem_array.sv
// Word storage behind cross_bar_slave_mem.
//   clk, aresetn      : clock and synchronous active-low reset (loads INIT_VALUE everywhere).
//   we, waddr, wdata  : single write port, committed on the rising edge.
//   raddr, rdata      : asynchronous read port.
module cross_bar_slave_mem_array
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter data_t       INIT_VALUE = '0,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  data_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output data_t            rdata
);

    data_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cross_bar_slave_mem.sv
// Slave-side responder for the crossbar req/ack protocol, backed by a small register file.
//   clk, aresetn            : clock, synchronous active-low reset.
//   slave_req/addr/cmd/wdata: request from the crossbar, held until ack.
//   slave_ack, slave_rdata  : registered one-cycle completion pulse and read data.
//   stall                   : freezes the wait-state counter while high.
//   rd_cnt, wr_cnt          : saturating counts of completed reads and writes.
module cross_bar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter data_t       INIT_VALUE  = '0
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             slave_req,
    input  addr_t            slave_addr,
    input  logic             slave_cmd,
    input  data_t            slave_wdata,
    output logic             slave_ack,
    output data_t            slave_rdata,
    input  logic             stall,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);

    slave_mem_state_e state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    addr_t            addr_q, addr_d;
    slave_cmd_e       cmd_q, cmd_d;
    data_t            wdata_q, wdata_d;
    logic             ack_q;
    data_t            rdata_q;
    logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

    logic             done;
    logic             mem_we;
    data_t            mem_rdata;

    // Completion happens on the edge leaving RESP, so ack becomes visible one cycle later,
    // giving the t+1+WAIT_CYCLES latency. Dropping req before that edge aborts the request.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (slave_req) begin
                    addr_d  = slave_addr;
                    cmd_d   = slave_cmd_e'(slave_cmd);
                    wdata_d = slave_wdata;
                    wait_d  = WAIT_INIT;
                    state_d = HAS_WAIT ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!slave_req) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else if (!stall) begin
                    wait_d = wait_q - 4'd1;
                    // Counter reaches zero on this edge.
                    if (wait_q <= 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                wait_d  = '0;
                done    = slave_req;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = done && (cmd_q == CMD_WRITE);

    cross_bar_slave_mem_array #(
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk     (clk),
        .aresetn (aresetn),
        .we      (mem_we),
        .waddr   (addr_q[IDX_W-1:0]),
        .wdata   (wdata_q),
        .raddr   (addr_q[IDX_W-1:0]),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            addr_q   <= '0;
            cmd_q    <= CMD_READ;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            ack_q   <= done;
            rdata_q <= (done && (cmd_q == CMD_READ)) ? mem_rdata : '0;
            if (done && (cmd_q == CMD_READ)) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (mem_we) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    assign slave_ack   = ack_q;
    assign slave_rdata = rdata_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
module tb_cross_bar_slave_mem;
    import cross_bar_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = 2;
    localparam data_t       INIT  = 32'hA5A5_0001;
    localparam int          SAT   = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic aresetn = 1'b0;

    // Instance with two wait states.
    logic        req = 1'b0, cmd = 1'b0, stall = 1'b0;
    addr_t       addr = '0;
    data_t       wdata = '0;
    logic        ack;
    data_t       rdata;
    logic [15:0] rd_cnt, wr_cnt;

    // Instance with zero wait states for back-to-back traffic.
    logic        req0 = 1'b0, cmd0 = 1'b0, stall0 = 1'b0;
    addr_t       addr0 = '0;
    data_t       wdata0 = '0;
    logic        ack0;
    data_t       rdata0;
    logic [15:0] rd_cnt0, wr_cnt0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain word array and completion counts.
    data_t mem_m [DEPTH];
    int    rd_m, wr_m, rd0_m, wr0_m;

    always #5 clk = ~clk;

    cross_bar_slave_mem #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W),
        .INIT_VALUE  (INIT)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .slave_req   (req),
        .slave_addr  (addr),
        .slave_cmd   (cmd),
        .slave_wdata (wdata),
        .slave_ack   (ack),
        .slave_rdata (rdata),
        .stall       (stall),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    cross_bar_slave_mem #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (0),
        .INIT_VALUE  (INIT)
    ) dut0 (
        .clk         (clk),
        .aresetn     (aresetn),
        .slave_req   (req0),
        .slave_addr  (addr0),
        .slave_cmd   (cmd0),
        .slave_wdata (wdata0),
        .slave_ack   (ack0),
        .slave_rdata (rdata0),
        .stall       (stall0),
        .rd_cnt      (rd_cnt0),
        .wr_cnt      (wr_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
        rd_m = 0; wr_m = 0; rd0_m = 0; wr0_m = 0;
    endtask

    // One request on the wait-state instance. stall_len edges right after acceptance are stalled;
    // later stall activity only lands in IDLE/RESP and must be ignored.
    task automatic txn(input logic c, input addr_t a, input data_t d, input int stall_len);
        int    lat = -1;
        int    idx = int'(a % DEPTH);
        int    bound = W + 1 + stall_len + 8;
        data_t exp_rd = (c == 1'b0) ? mem_m[idx] : '0;
        req = 1'b1; cmd = c; addr = a; wdata = d;
        stall = 1'($urandom_range(0, 1));
        for (int k = 0; k <= bound; k++) begin
            step();
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
            if (k < stall_len) stall = 1'b1;
            else if (k >= stall_len + W) stall = 1'($urandom_range(0, 1));
            else stall = 1'b0;
            // Fields are captured at acceptance; scramble them afterwards.
            addr = $urandom; wdata = $urandom; cmd = 1'($urandom_range(0, 1));
        end
        check("ack_latency", 32'(lat), 32'(W + 1 + stall_len));
        if (lat >= 0) begin
            check("rdata", rdata, exp_rd);
            if (c) begin
                mem_m[idx] = d;
                wr_m = sat(wr_m + 1);
            end else begin
                rd_m = sat(rd_m + 1);
            end
            check("rd_cnt", 32'(rd_cnt), 32'(rd_m));
            check("wr_cnt", 32'(wr_cnt), 32'(wr_m));
        end
        req = 1'b0;
        stall = 1'($urandom_range(0, 1));
        step();
        check("ack_pulse_end", 32'(ack), 32'd0);
        check("rdata_after_ack", rdata, 32'd0);
    endtask

    initial begin
        model_reset();
        step();
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        aresetn = 1'b1;
        step();

        // Basic write/read, aliasing, stall.
        txn(1'b1, 32'd3, 32'hDEADBEEF, 0);
        txn(1'b0, 32'd3, 32'h0, 0);
        txn(1'b1, 32'h0000_0013, 32'h5A5A5A5A, 0);
        txn(1'b0, 32'd3, 32'h0, 0);
        txn(1'b0, 32'd3, 32'h0, 4);

        // Abort: request dropped during WAIT.
        req = 1'b1; cmd = 1'b1; addr = 32'd5; wdata = 32'hBAD0_BAD0;
        step();
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("abort_no_ack", 32'(ack), 32'd0);
        end
        check("abort_wr_cnt", 32'(wr_cnt), 32'(wr_m));
        txn(1'b0, 32'd5, 32'h0, 0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 4)));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                stall = 1'($urandom_range(0, 1));
                addr = $urandom;
                step();
            end
        end

        // Back-to-back on the zero-wait instance: ack every second cycle.
        req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h1234_5678;
        for (int k = 0; k < 10; k++) begin
            stall0 = 1'($urandom_range(0, 1));
            step();
            check("b2b_wr_ack", 32'(ack0), 32'(k % 2));
        end
        req0 = 1'b0;
        wr0_m = 5;
        step();
        check("b2b_wr_cnt", 32'(wr_cnt0), 32'(wr0_m));
        req0 = 1'b1; cmd0 = 1'b0; addr0 = 32'h0000_0107;
        for (int k = 0; k < 10; k++) begin
            step();
            check("b2b_rd_ack", 32'(ack0), 32'(k % 2));
            if (k % 2 == 1) check("b2b_rdata", rdata0, 32'h1234_5678);
        end
        req0 = 1'b0;
        rd0_m = 5;
        step();
        check("b2b_rd_cnt", 32'(rd_cnt0), 32'(rd0_m));

        // Saturation: preload the read counter near the top, then keep reading.
        force dut0.rd_cnt_q = 16'hFFFD;
        step();
        release dut0.rd_cnt_q;
        step();
        rd0_m = 32'hFFFD;
        check("sat_preload", 32'(rd_cnt0), 32'(rd0_m));
        req0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k % 2 == 1) rd0_m = sat(rd0_m + 1);
            check("sat_rd_cnt", 32'(rd_cnt0), 32'(rd0_m));
        end
        req0 = 1'b0;
        step();

        // Reset while a write sits in WAIT.
        req = 1'b1; cmd = 1'b1; addr = 32'd9; wdata = 32'hCAFE_F00D;
        step();
        step();
        aresetn = 1'b0;
        step();
        model_reset();
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_mid_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_mid_rd_cnt0", 32'(rd_cnt0), 32'd0);
        req = 1'b0;
        aresetn = 1'b1;
        step();
        txn(1'b0, 32'd3, 32'h0, 0);
        txn(1'b0, 32'd9, 32'h0, 0);
        txn(1'b0, 32'd7, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
